// File: rtl/axi4stream_row_packer.sv
// AXI4-Stream row packer: gathers narrow stream beats into an N_ROWS x ROW_SIZE
// frame and presents it through a registered valid/ready output with a
// one-frame skid (the fill register doubles as the held frame while the output
// slot is occupied). Protocol errors are reported as per-frame qualifiers.
module axi4stream_row_packer #(
  parameter int AXI_PACKET_SIZE = 8,
  parameter int ROW_SIZE        = 20,
  parameter int N_ROWS          = 2,
  parameter int BUFFER_SIZE     = ROW_SIZE * N_ROWS
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [AXI_PACKET_SIZE-1:0] tdata,
  input  logic                       tvalid,
  input  logic                       tlast,
  output logic                       tready,
  output logic [BUFFER_SIZE-1:0]     buffer,
  output logic                       valid,
  input  logic                       ready,
  output logic                       err_short,
  output logic                       err_long
);

  localparam int BEATS_PER_ROW = (ROW_SIZE + AXI_PACKET_SIZE - 1) / AXI_PACKET_SIZE;
  // Bits kept from the last beat of each row; its upper bits fall off the row.
  localparam int LAST_BITS = ROW_SIZE - (BEATS_PER_ROW - 1) * AXI_PACKET_SIZE;
  localparam logic [31:0] LAST_BEAT = 32'(BEATS_PER_ROW - 1);
  localparam logic [31:0] LAST_ROW  = 32'(N_ROWS - 1);

  if ((BUFFER_SIZE != ROW_SIZE * N_ROWS) || (AXI_PACKET_SIZE < 1) ||
      (ROW_SIZE < 1) || (N_ROWS < 1)) begin : g_bad_params
    $error("axi4stream_row_packer: illegal parameters (BUFFER_SIZE must equal ROW_SIZE*N_ROWS)");
  end

  typedef enum logic [1:0] {
    S_FILL    = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t                 state_r, state_n;
  logic [BUFFER_SIZE-1:0] fill_r, fill_n;
  logic [BUFFER_SIZE-1:0] buffer_r, buffer_n;
  logic                   valid_r, valid_n;
  logic                   err_short_r, err_short_n;
  logic                   err_long_r, err_long_n;
  logic                   pend_short_r, pend_short_n;
  logic                   pend_long_r, pend_long_n;
  logic [31:0]            beat_idx_r, beat_idx_n;
  logic [31:0]            row_idx_r, row_idx_n;

  logic [BUFFER_SIZE-1:0] wr_fill_s;
  logic                   tready_s;
  logic                   accept_s;
  logic                   last_in_row_s;
  logic                   final_s;
  logic                   slot_free_s;
  logic                   is_short_s;
  logic                   is_long_s;

  // Each beat slot has a fixed bit offset; the slot addressed by the counters
  // takes the incoming beat (assignment, not accumulation), all others hold.
  for (genvar r = 0; r < N_ROWS; r++) begin : g_row
    for (genvar k = 0; k < BEATS_PER_ROW; k++) begin : g_beat
      localparam int OFF = r * ROW_SIZE + k * AXI_PACKET_SIZE;
      localparam int W   = (k == BEATS_PER_ROW - 1) ? LAST_BITS : AXI_PACKET_SIZE;
      assign wr_fill_s[OFF +: W] = ((row_idx_r == 32'(r)) && (beat_idx_r == 32'(k))) ?
                                   tdata[W-1:0] : fill_r[OFF +: W];
    end
  end

  // Upstream is stalled only while a completed frame waits for the output slot,
  // and is forced low for the whole time reset is asserted.
  assign tready_s      = ~areset & (state_r != S_HOLD);
  assign accept_s      = tvalid & tready_s;
  assign last_in_row_s = (beat_idx_r == LAST_BEAT);
  assign final_s       = last_in_row_s & (row_idx_r == LAST_ROW);
  assign slot_free_s   = ~valid_r | ready;
  assign is_short_s    = tlast & ~final_s;
  assign is_long_s     = final_s & ~tlast;

  assign tready    = tready_s;
  assign buffer    = buffer_r;
  assign valid     = valid_r;
  assign err_short = err_short_r;
  assign err_long  = err_long_r;

  // Next-state, packing counters and output-slot loading.
  always_comb begin
    state_n      = state_r;
    fill_n       = fill_r;
    buffer_n     = buffer_r;
    valid_n      = valid_r & ~ready;
    err_short_n  = err_short_r;
    err_long_n   = err_long_r;
    pend_short_n = pend_short_r;
    pend_long_n  = pend_long_r;
    beat_idx_n   = beat_idx_r;
    row_idx_n    = row_idx_r;
    case (state_r)
      S_FILL: begin
        if (accept_s) begin
          fill_n = wr_fill_s;
          if (tlast || final_s) begin
            beat_idx_n = 32'd0;
            row_idx_n  = 32'd0;
            if (slot_free_s) begin
              buffer_n    = wr_fill_s;
              valid_n     = 1'b1;
              err_short_n = is_short_s;
              err_long_n  = is_long_s;
              fill_n      = '0;
              state_n     = is_long_s ? S_DISCARD : S_FILL;
            end else begin
              pend_short_n = is_short_s;
              pend_long_n  = is_long_s;
              state_n      = S_HOLD;
            end
          end else if (last_in_row_s) begin
            beat_idx_n = 32'd0;
            row_idx_n  = row_idx_r + 32'd1;
          end else begin
            beat_idx_n = beat_idx_r + 32'd1;
          end
        end else begin
          state_n = S_FILL;
        end
      end
      S_HOLD: begin
        if (valid_r && ready) begin
          buffer_n    = fill_r;
          valid_n     = 1'b1;
          err_short_n = pend_short_r;
          err_long_n  = pend_long_r;
          fill_n      = '0;
          state_n     = pend_long_r ? S_DISCARD : S_FILL;
        end else begin
          state_n = S_HOLD;
        end
      end
      S_DISCARD: begin
        if (accept_s && tlast) begin
          state_n = S_FILL;
        end else begin
          state_n = S_DISCARD;
        end
      end
      default: begin
        state_n    = S_FILL;
        fill_n     = '0;
        beat_idx_n = 32'd0;
        row_idx_n  = 32'd0;
      end
    endcase
  end

  // State and datapath registers; reset drops any partial or held frame.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r      <= S_FILL;
      fill_r       <= '0;
      buffer_r     <= '0;
      valid_r      <= 1'b0;
      err_short_r  <= 1'b0;
      err_long_r   <= 1'b0;
      pend_short_r <= 1'b0;
      pend_long_r  <= 1'b0;
      beat_idx_r   <= 32'd0;
      row_idx_r    <= 32'd0;
    end else begin
      state_r      <= state_n;
      fill_r       <= fill_n;
      buffer_r     <= buffer_n;
      valid_r      <= valid_n;
      err_short_r  <= err_short_n;
      err_long_r   <= err_long_n;
      pend_short_r <= pend_short_n;
      pend_long_r  <= pend_long_n;
      beat_idx_r   <= beat_idx_n;
      row_idx_r    <= row_idx_n;
    end
  end

endmodule

// File: tb/tb_axi4stream_row_packer.sv
// Bench for axi4stream_row_packer: directed scenarios plus a randomized run
// against a packet-level reference model (frames built from whole packets).
module tb_axi4stream_row_packer;

  localparam int AXI   = 8;
  localparam int ROW   = 20;
  localparam int NR    = 2;
  localparam int BUF   = ROW * NR;
  localparam int BPR   = (ROW + AXI - 1) / AXI;
  localparam int BPF   = BPR * NR;
  localparam int LASTW = ROW - (BPR - 1) * AXI;

  typedef logic [BUF+1:0] frame_t; // {err_short, err_long, buffer}

  localparam logic [7:0] BASIC [0:5] = '{8'h11, 8'h22, 8'h3A, 8'h44, 8'h55, 8'h6B};
  localparam frame_t F_BASIC = {2'b00, 40'hB5544A2211};
  localparam frame_t F_SHORT = {2'b10, 40'h0000002211};
  localparam frame_t F_LONG  = {2'b01, 40'h6050430201};
  localparam frame_t F_B2B   = {2'b00, 40'h6A5A43A2A1};

  logic           aclk = 1'b0;
  logic           areset;
  logic [AXI-1:0] tdata;
  logic           tvalid;
  logic           tlast;
  logic           tready;
  logic [BUF-1:0] buffer;
  logic           valid;
  logic           ready;
  logic           err_short;
  logic           err_long;

  axi4stream_row_packer #(
    .AXI_PACKET_SIZE(AXI),
    .ROW_SIZE(ROW),
    .N_ROWS(NR),
    .BUFFER_SIZE(BUF)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .tdata(tdata),
    .tvalid(tvalid),
    .tlast(tlast),
    .tready(tready),
    .buffer(buffer),
    .valid(valid),
    .ready(ready),
    .err_short(err_short),
    .err_long(err_long)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: completed frames not yet consumed, current packet, discard flag.
  frame_t         exp_q[$];
  logic [AXI-1:0] pkt_q[$];
  bit             disc = 1'b0;

  // Per-cycle observations from the last call of cycle().
  bit     c_acc, c_hs;
  logic   c_tready, c_valid, c_exp_tready, c_exp_valid;
  frame_t c_obs, c_exp;

  function automatic frame_t build_frame(input bit sh, input bit lg);
    logic [BUF-1:0] f;
    int r, k, w;
    f = '0;
    for (int i = 0; i < pkt_q.size(); i++) begin
      r = i / BPR;
      k = i % BPR;
      w = (k == BPR - 1) ? LASTW : AXI;
      for (int b = 0; b < w; b++) f[r * ROW + k * AXI + b] = pkt_q[i][b];
    end
    return {sh, lg, f};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    pkt_q.delete();
    disc = 1'b0;
  endtask

  task automatic model_beat(input logic [AXI-1:0] d, input logic l);
    if (disc) begin
      if (l) disc = 1'b0;
    end else begin
      pkt_q.push_back(d);
      if (l || pkt_q.size() == BPF) begin
        exp_q.push_back(build_frame(l && (pkt_q.size() < BPF), !l));
        if (!l) disc = 1'b1;
        pkt_q.delete();
      end
    end
  endtask

  // One clock: drive at negedge, observe, update model, wait for the edge.
  task automatic cycle(input logic tv, input logic [AXI-1:0] td, input logic tl, input logic rd);
    @(negedge aclk);
    tvalid = tv; tdata = td; tlast = tl; ready = rd;
    #1;
    c_acc        = tvalid && tready;
    c_hs         = valid && ready;
    c_tready     = tready;
    c_valid      = valid;
    c_obs        = {err_short, err_long, buffer};
    c_exp_tready = (exp_q.size() < 2);
    c_exp_valid  = (exp_q.size() > 0);
    c_exp        = '0;
    if (c_hs && exp_q.size() > 0) c_exp = exp_q.pop_front();
    if (c_acc) model_beat(td, tl);
    @(posedge aclk);
  endtask

  task automatic send_beat(input logic [AXI-1:0] d, input logic l, input logic rd, output int tries);
    tries = 0;
    do begin
      cycle(1'b1, d, l, rd);
      tries++;
    end while (!c_acc && tries < 40);
    if (!c_acc) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: beat %h not accepted after %0d cycles", d, tries);
    end
  endtask

  task automatic send_basic(input logic rd);
    int t;
    for (int i = 0; i < 6; i++) send_beat(BASIC[i], (i == 5), rd, t);
  endtask

  task automatic test_reset();
    areset = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = '0; ready = 1'b0;
    model_reset();
    repeat (3) @(posedge aclk);
    #1;
    if (tready !== 1'b0) begin n_bad++; $display("FAIL reset_tready: got %b want 0", tready); end n_cmp++;
    if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid); end n_cmp++;
    if (buffer !== '0) begin n_bad++; $display("FAIL reset_buffer: got %h want 0", buffer); end n_cmp++;
    if (err_short !== 1'b0) begin n_bad++; $display("FAIL reset_err_short: got %b want 0", err_short); end n_cmp++;
    if (err_long !== 1'b0) begin n_bad++; $display("FAIL reset_err_long: got %b want 0", err_long); end n_cmp++;
    @(negedge aclk);
    areset = 1'b0;
    #1;
    if (tready !== 1'b1) begin n_bad++; $display("FAIL reset_release_tready: got %b want 1", tready); end n_cmp++;
  endtask

  task automatic test_basic();
    send_basic(1'b1);
    if (c_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid: got %b want 0", c_valid); end n_cmp++;
    cycle(1'b0, '0, 1'b0, 1'b1);
    if (c_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", c_valid); end n_cmp++;
    if (c_obs !== F_BASIC) begin n_bad++; $display("FAIL basic_frame: got %h want %h", c_obs, F_BASIC); end n_cmp++;
    cycle(1'b0, '0, 1'b0, 1'b1);
    if (c_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_fall: got %b want 0", c_valid); end n_cmp++;
  endtask

  task automatic test_short();
    int t;
    send_beat(8'h11, 1'b0, 1'b1, t);
    send_beat(8'h22, 1'b1, 1'b1, t);
    cycle(1'b0, '0, 1'b0, 1'b1);
    if (c_obs !== F_SHORT || c_valid !== 1'b1) begin n_bad++; $display("FAIL short_frame: got %h valid %b want %h", c_obs, c_valid, F_SHORT); end n_cmp++;
    send_basic(1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    if (c_obs !== F_BASIC) begin n_bad++; $display("FAIL short_next_frame: got %h want %h", c_obs, F_BASIC); end n_cmp++;
  endtask

  task automatic test_long();
    int t7, t8;
    logic [AXI-1:0] d;
    for (int i = 1; i <= 6; i++) begin
      d = AXI'(i);
      send_beat(d, 1'b0, 1'b1, t7);
    end
    send_beat(8'h07, 1'b0, 1'b1, t7);
    if (c_obs !== F_LONG || c_valid !== 1'b1) begin n_bad++; $display("FAIL long_frame: got %h valid %b want %h", c_obs, c_valid, F_LONG); end n_cmp++;
    send_beat(8'h08, 1'b1, 1'b1, t8);
    if (t7 != 1) begin n_bad++; $display("FAIL long_discard_ready7: got %0d cycles want 1", t7); end n_cmp++;
    if (t8 != 1) begin n_bad++; $display("FAIL long_discard_ready8: got %0d cycles want 1", t8); end n_cmp++;
    send_basic(1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    if (c_obs !== F_BASIC) begin n_bad++; $display("FAIL long_next_frame: got %h want %h", c_obs, F_BASIC); end n_cmp++;
  endtask

  task automatic test_back_to_back();
    int t;
    logic [AXI-1:0] d;
    send_basic(1'b0);
    for (int i = 1; i <= 6; i++) begin
      d = AXI'(8'hA0 + i);
      send_beat(d, (i == 6), 1'b0, t);
    end
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    if (c_tready !== 1'b0) begin n_bad++; $display("FAIL b2b_hold_tready: got %b want 0", c_tready); end n_cmp++;
    if (c_obs !== F_BASIC || c_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_held_first: got %h valid %b want %h", c_obs, c_valid, F_BASIC); end n_cmp++;
    cycle(1'b0, '0, 1'b0, 1'b1);
    if (c_obs !== F_BASIC) begin n_bad++; $display("FAIL b2b_first_handoff: got %h want %h", c_obs, F_BASIC); end n_cmp++;
    cycle(1'b0, '0, 1'b0, 1'b0);
    if (c_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid_continuous: got %b want 1", c_valid); end n_cmp++;
    if (c_tready !== 1'b1) begin n_bad++; $display("FAIL b2b_tready_after: got %b want 1", c_tready); end n_cmp++;
    if (c_obs !== F_B2B) begin n_bad++; $display("FAIL b2b_second_frame: got %h want %h", c_obs, F_B2B); end n_cmp++;
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    if (c_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drained: got %b want 0", c_valid); end n_cmp++;
  endtask

  task automatic test_reset_midframe();
    int t;
    send_basic(1'b0);
    for (int i = 0; i < 4; i++) send_beat(8'hFF, 1'b0, 1'b0, t);
    @(negedge aclk);
    tvalid = 1'b0;
    #2;
    areset = 1'b1;
    #1;
    if (valid !== 1'b0) begin n_bad++; $display("FAIL midreset_valid: got %b want 0", valid); end n_cmp++;
    if (buffer !== '0) begin n_bad++; $display("FAIL midreset_buffer: got %h want 0", buffer); end n_cmp++;
    if (tready !== 1'b0) begin n_bad++; $display("FAIL midreset_tready: got %b want 0", tready); end n_cmp++;
    model_reset();
    @(negedge aclk);
    areset = 1'b0;
    send_basic(1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    if (c_obs !== F_BASIC || c_valid !== 1'b1) begin n_bad++; $display("FAIL midreset_clean_frame: got %h valid %b want %h", c_obs, c_valid, F_BASIC); end n_cmp++;
  endtask

  task automatic test_random();
    int budget, len, b;
    logic [AXI-1:0] d;
    logic tv, rd;
    budget = 0;
    for (int p = 0; p < 100; p++) begin
      len = $urandom_range(1, BPF + 2);
      b = 0;
      d = AXI'($urandom);
      while (b < len && budget < 20000) begin
        tv = ($urandom_range(0, 3) != 0);
        rd = ($urandom_range(0, 2) != 0);
        cycle(tv, d, (b == len - 1), rd);
        budget++;
        if (c_tready !== c_exp_tready) begin n_bad++; $display("FAIL rand_tready: got %b want %b (pkt %0d)", c_tready, c_exp_tready, p); end n_cmp++;
        if (c_valid !== c_exp_valid) begin n_bad++; $display("FAIL rand_valid: got %b want %b (pkt %0d)", c_valid, c_exp_valid, p); end n_cmp++;
        if (c_hs && c_exp_valid) begin
          if (c_obs !== c_exp) begin n_bad++; $display("FAIL rand_frame: got %h want %h (pkt %0d)", c_obs, c_exp, p); end n_cmp++;
        end
        if (c_acc) begin
          b++;
          d = AXI'($urandom);
        end
      end
    end
    if (budget >= 20000) begin n_cmp++; n_bad++; $display("FAIL rand_budget: %0d cycles used", budget); end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b1);
      if (c_hs && c_exp_valid) begin
        if (c_obs !== c_exp) begin n_bad++; $display("FAIL rand_drain_frame: got %h want %h", c_obs, c_exp); end n_cmp++;
      end
    end
    if (exp_q.size() != 0 || valid !== 1'b0) begin n_bad++; $display("FAIL rand_leftover: %0d frames pending, valid %b want 0/0", exp_q.size(), valid); end n_cmp++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_long();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi4stream_row_packer.md
Name: axi4stream_row_packer

Overview:
- Parametrised AXI4-Stream slave that packs a stream of narrow beats into a frame of N_ROWS rows, each ROW_SIZE bits wide.
- Beats never straddle a row boundary.
- The completed frame is presented on a registered output with valid/ready handshake, protocol-error flags and a one-frame skid, so upstream DMA sees backpressure instead of silent corruption.
- Sits between the DMA MM2S stream and the upscaler line/kernel logic.

Parameters:
- AXI_PACKET_SIZE, 8, tdata width in bits (>=1).
- ROW_SIZE, 20, bits per row (>=1).
- N_ROWS, 2, rows per frame (>=1).
- BUFFER_SIZE, ROW_SIZE*N_ROWS, output frame width. Must equal ROW_SIZE*N_ROWS; any other value is an elaboration error.
- Derived BEATS_PER_ROW = ceil(ROW_SIZE/AXI_PACKET_SIZE); BEATS_PER_FRAME = BEATS_PER_ROW*N_ROWS.

Ports:
- aclk  in  1  clock, all logic rising-edge.
- areset  in  1  reset, asynchronous, active-high.
- tdata  in  AXI_PACKET_SIZE  stream data.
- tvalid  in  1  stream valid.
- tlast  in  1  end of stream packet.
- tready  out  1  stream ready.
- buffer  out  BUFFER_SIZE  packed frame; row r occupies bits [(r+1)*ROW_SIZE-1 : r*ROW_SIZE].
- valid  out  1  buffer holds a complete frame.
- ready  in  1  consumer accepts the frame when valid&ready.
- err_short  out  1  frame qualifier: tlast arrived before BEATS_PER_FRAME beats.
- err_long  out  1  frame qualifier: final beat arrived without tlast; excess beats were discarded.

Behaviour:
- Reset (async assert, sync release):
  - buffer=0, valid=0, err_short=0, err_long=0.
  - Fill register=0, beat/row counters=0, state=FILL.
  - tready=0 while areset is high.
- Beat accepted when tvalid&tready.
- Packing: beat k of row r (k=0..BEATS_PER_ROW-1) is written at bit offset r*ROW_SIZE + k*AXI_PACKET_SIZE. The last beat of a row keeps only the low ROW_SIZE-(BEATS_PER_ROW-1)*AXI_PACKET_SIZE bits; its upper bits are dropped.
- Writes are assignments, not OR-accumulation. The fill register is cleared when a frame is handed off.
- States:
  - FILL: tready=1. Accept beats and advance beat_idx, then row_idx.
    - Frame completes on the BEATS_PER_FRAME-th beat, or early on any beat with tlast.
    - Early tlast: unfilled bits=0 and err_short is set for that frame.
    - Final beat without tlast: err_long is set for that frame, and the next state after handoff is DISCARD.
    - At completion, if the output slot is free, or is being emptied this cycle (valid&ready), the frame moves to buffer on the same edge: valid=1 the cycle after the final beat, fill cleared. Otherwise go to HOLD.
  - HOLD: tready=0. When valid&ready, move fill to buffer on that edge, then go to DISCARD if err_long is pending, else FILL. Zero-bubble: valid stays 1.
  - DISCARD: tready=1. Beats are dropped. The beat carrying tlast returns to FILL; the next beat starts a new frame.
- Output:
  - valid falls after valid&ready unless a new frame loads on the same edge.
  - buffer, err_short and err_long are stable while valid=1 and ready=0.
- Counters are 32-bit or wider, and compare against derived constants, not products of row_idx.
- tlast on the exact final beat counts as a normal completion with no flags.
- Single-beat frame (BEATS_PER_FRAME=1): completes every accepted beat.
- Reset mid-frame or mid-HOLD discards all partial and held data with no output.

Test Plan:
- Defaults; beats 0x11,0x22,0x3A,0x44,0x55,0x6B, tlast on 6th, ready=1 -> one cycle after the 6th beat: valid=1, buffer=0xB5544A2211, err_short=0, err_long=0.
- Beats 0x11,0x22 with tlast on 2nd -> buffer=0x0000002211, err_short=1. Next 6-beat packet packs from offset 0.
- 8 beats 0x01..0x08, tlast on 8th -> frame from beats 1-6 with err_long=1; beats 7-8 dropped (tready=1 in DISCARD). Next packet is clean.
- ready=0; send two full frames back-to-back -> first frame held on buffer; second fills, then tready=0 (HOLD). Raise ready for 1 cycle -> buffer=second frame with valid continuously 1 and tready=1 the next cycle.
- Assert areset after 4 beats -> valid=0, buffer=0, tready=0 asynchronously. After release, a 6-beat frame yields correct data with no stale bits.
- tvalid toggling randomly and ready toggling randomly over 100 frames -> every frame matches the scoreboard, and no beat is accepted while tready=0.
